// File: rtl/arq_tx_ctrl_if.sv
// arq_tx_ctrl_if: FIFO, serializer, retransmit RAM, ACK line and status bundle of the ARQ transmit controller.
interface arq_tx_ctrl_if;
  logic        i_arq_en;
  logic        i_fifo_valid;
  logic [7:0]  i_fifo_data;
  logic        i_fifo_fas;
  logic        o_fifo_ready;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;
  logic        o_mem_we;
  logic [12:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_rdata;
  logic        i_otn_tx_ack;
  logic        o_retrans_req;
  logic        o_frame_done;
  logic        o_frame_drop;
  logic        o_busy;
  modport master (
    input  i_arq_en, i_fifo_valid, i_fifo_data, i_fifo_fas, i_tx_ready, i_mem_rdata, i_otn_tx_ack,
    output o_fifo_ready, o_tx_valid, o_tx_data, o_mem_we, o_mem_addr, o_mem_wdata,
           o_retrans_req, o_frame_done, o_frame_drop, o_busy
  );
  modport slave (
    output i_arq_en, i_fifo_valid, i_fifo_data, i_fifo_fas, i_tx_ready, i_mem_rdata, i_otn_tx_ack,
    input  o_fifo_ready, o_tx_valid, o_tx_data, o_mem_we, o_mem_addr, o_mem_wdata,
           o_retrans_req, o_frame_done, o_frame_drop, o_busy
  );
endinterface

// File: rtl/arq_tx_ctrl.sv
// arq_tx_ctrl: streams FIFO frames to the serializer, buffers them for replay and runs the 3-bit ACK retry loop.
module arq_tx_ctrl #(
  parameter int FRAME_BYTES = 4164,
  parameter int ACK_TIMEOUT = 16384,
  parameter int MAX_RETRY   = 3
) (
  input logic           i_clk,
  input logic           i_rst,
  arq_tx_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_ACK_WAIT, S_ACK_BIT, S_ACK_STOP, S_RETX_PRIME, S_RETX_SEND
  } state_t;
  localparam logic [12:0] LAST_BYTE = 13'(FRAME_BYTES - 1);
  localparam logic [15:0] LAST_TICK = 16'(ACK_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
  state_t      r_state;
  logic [12:0] r_byte_cnt;
  logic [12:0] r_rd_ptr;
  logic [15:0] r_timer;
  logic [3:0]  r_retry;
  logic [2:0]  r_ack_sync;
  logic        r_ack_val;
  logic        r_done;
  logic        r_drop;
  logic        w_run;
  logic        w_ack_s;
  logic        w_pass;
  logic        w_retx;
  logic        w_fifo_hs;
  logic        w_tx_hs;
  logic        w_bad;
  logic [12:0] w_rd_next;
  // The FAS byte seen in IDLE already travels the SEND path, so it is gated by the serializer too.
  always_comb begin
    w_run     = !i_rst;
    w_ack_s   = r_ack_sync[2];
    w_pass    = r_state == S_SEND || (r_state == S_IDLE && bus.i_fifo_fas);
    w_retx    = r_state == S_RETX_SEND;
    w_fifo_hs = w_run && bus.i_fifo_valid && (w_pass ? bus.i_tx_ready : r_state == S_IDLE);
    w_tx_hs   = w_run && bus.i_tx_ready && (w_pass ? bus.i_fifo_valid : w_retx);
    w_rd_next = r_rd_ptr + {12'd0, w_tx_hs};
    w_bad     = (r_state == S_ACK_WAIT && w_ack_s && r_timer == LAST_TICK) ||
                (r_state == S_ACK_STOP && !(!w_ack_s && r_ack_val));
  end
  assign bus.o_fifo_ready  = w_run && (w_pass ? bus.i_tx_ready : r_state == S_IDLE);
  assign bus.o_tx_valid    = w_run && (w_pass ? bus.i_fifo_valid : w_retx);
  assign bus.o_tx_data     = !w_run ? 8'd0 : w_pass ? bus.i_fifo_data : w_retx ? bus.i_mem_rdata : 8'd0;
  assign bus.o_mem_we      = w_pass && w_fifo_hs;
  assign bus.o_mem_addr    = !w_run ? 13'd0 : r_state == S_SEND ? r_byte_cnt : w_retx ? w_rd_next : 13'd0;
  assign bus.o_mem_wdata   = bus.o_mem_we ? bus.i_fifo_data : 8'd0;
  assign bus.o_retrans_req = w_run && (r_state == S_RETX_PRIME || w_retx);
  assign bus.o_busy        = w_run && r_state != S_IDLE;
  assign bus.o_frame_done  = r_done;
  assign bus.o_frame_drop  = r_drop;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_rd_ptr   <= '0;
      r_timer    <= '0;
      r_retry    <= '0;
      r_ack_sync <= '1;
      r_ack_val  <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_ack_sync <= {r_ack_sync[1:0], bus.i_otn_tx_ack};
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      case (r_state)
        S_IDLE: if (w_pass && w_fifo_hs) begin
          r_state    <= S_SEND;
          r_byte_cnt <= 13'd1;
        end
        S_SEND: if (w_fifo_hs) begin
          r_byte_cnt <= r_byte_cnt + 13'd1;
          if (r_byte_cnt == LAST_BYTE) begin
            r_state <= bus.i_arq_en ? S_ACK_WAIT : S_IDLE;
            r_done  <= !bus.i_arq_en;
            r_retry <= '0;
            r_timer <= '0;
          end
        end
        S_ACK_WAIT: begin
          r_timer <= r_timer + 16'd1;
          if (!w_ack_s) r_state <= S_ACK_BIT;
        end
        S_ACK_BIT: begin
          r_ack_val <= w_ack_s;
          r_state   <= S_ACK_STOP;
        end
        S_ACK_STOP: if (!w_ack_s && r_ack_val) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_RETX_PRIME: begin
          r_rd_ptr <= '0;
          r_state  <= S_RETX_SEND;
        end
        S_RETX_SEND: if (w_tx_hs) begin
          r_rd_ptr <= w_rd_next;
          if (r_rd_ptr == LAST_BYTE) begin
            r_state <= S_ACK_WAIT;
            r_timer <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Timeout, NAK and framing errors all funnel into the same retry decision.
      if (w_bad) begin
        r_drop  <= r_retry == RETRY_MAX;
        r_retry <= r_retry == RETRY_MAX ? r_retry : r_retry + 4'd1;
        r_state <= r_retry == RETRY_MAX ? S_IDLE : S_RETX_PRIME;
      end
    end
  end
endmodule

// File: tb/tb_arq_tx_ctrl.sv
// tb_arq_tx_ctrl: directed frames against a queue-based model of the byte stream, RAM writes and ACK waits.
module tb_arq_tx_ctrl;
  localparam int FB = 16;
  localparam int TO = 100;
  localparam int MR = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  arq_tx_ctrl_if bus();
  arq_tx_ctrl #(.FRAME_BYTES(FB), .ACK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [8:0]  fifo_q[$];
  logic [8:0]  exp_tx[$];
  logic [20:0] exp_wr[$];
  int          waits[$];
  logic [7:0]  ram [0:8191];
  logic [7:0]  rdata_r = 8'd0;
  logic        fifo_pop = 1'b0;
  logic        bp = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  logic [8:0]  ev;
  logic [20:0] wv;
  int cyc = 0, n_done = 0, n_drop = 0, n_xfer = 0, n_rtx = 0, last_xfer = 0, done_cyc = 0, run = 0;
  int d_done, d_drop, d_xfer, d_rtx;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic extra(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=nothing", name, act);
  endtask
  always @(posedge clk) begin
    if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    rdata_r <= ram[bus.o_mem_addr];
  end
  assign bus.i_mem_rdata = rdata_r;
  initial begin
    bus.i_fifo_valid = 1'b0;
    bus.i_fifo_data  = 8'd0;
    bus.i_fifo_fas   = 1'b0;
    bus.i_tx_ready   = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (fifo_pop) void'(fifo_q.pop_front());
      bus.i_fifo_valid = fifo_q.size() != 0;
      {bus.i_fifo_fas, bus.i_fifo_data} = fifo_q.size() != 0 ? fifo_q[0] : 9'd0;
      bus.i_tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk) begin
    cyc++;
    fifo_pop = bus.i_fifo_valid && bus.o_fifo_ready;
    if (rst) run = 0;
    else begin
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        n_xfer++;
        last_xfer = cyc;
        if (bus.o_retrans_req) n_rtx++;
        if (exp_tx.size() == 0) extra("tx_extra", bus.o_tx_data);
        else begin
          ev = exp_tx.pop_front();
          chk("tx_data", bus.o_tx_data, ev[7:0]);
          chk("tx_retx", bus.o_retrans_req, ev[8]);
        end
      end
      if (prev_stall && bus.o_tx_valid) chk("tx_hold", bus.o_tx_data, prev_data);
      if (bus.o_mem_we) begin
        if (exp_wr.size() == 0) extra("wr_extra", bus.o_mem_addr);
        else begin
          wv = exp_wr.pop_front();
          chk("wr_addr", bus.o_mem_addr, wv[20:8]);
          chk("wr_data", bus.o_mem_wdata, wv[7:0]);
        end
      end
      if (bus.o_retrans_req) chk("retx_no_pop", bus.o_fifo_ready, 0);
      if (bus.o_frame_done) begin n_done++; done_cyc = cyc; end
      if (bus.o_frame_drop) n_drop++;
      if (bus.o_busy && !bus.o_tx_valid && !bus.o_retrans_req) run++;
      else if (run > 0) begin waits.push_back(run); run = 0; end
    end
    prev_stall = !rst && bus.o_tx_valid && !bus.i_tx_ready;
    prev_data  = bus.o_tx_data;
  end
  task automatic load_frame(input int junk, input logic [7:0] base, input int replays);
    for (int i = 0; i < junk; i++) fifo_q.push_back({1'b0, 8'hE0 + 8'(i)});
    for (int i = 0; i < FB; i++) begin
      fifo_q.push_back({i == 0, base + 8'(i)});
      exp_wr.push_back({13'(i), base + 8'(i)});
      exp_tx.push_back({1'b0, base + 8'(i)});
    end
    for (int r = 0; r < replays; r++)
      for (int i = 0; i < FB; i++) exp_tx.push_back({1'b1, base + 8'(i)});
  endtask
  task automatic wait_left(input int n, input int limit);
    int k = 0;
    while (exp_tx.size() > n && k < limit) begin @(posedge clk); #2; k++; end
    chk("wait_tx_timeout", exp_tx.size(), n);
  endtask
  task automatic wait_idle(input int limit);
    int k = 0;
    do begin @(posedge clk); #2; k++; end while (bus.o_busy && k < limit);
    chk("idle_timeout", bus.o_busy, 0);
    repeat (2) @(posedge clk);
    #2;
  endtask
  task automatic drive_ack(input logic a, input logic b, input logic c);
    @(posedge clk); #1 bus.i_otn_tx_ack = a;
    @(posedge clk); #1 bus.i_otn_tx_ack = b;
    @(posedge clk); #1 bus.i_otn_tx_ack = c;
    @(posedge clk); #1 bus.i_otn_tx_ack = 1'b1;
  endtask
  task automatic chk_quiet(input string name);
    chk({name, "_flags"}, {bus.o_fifo_ready, bus.o_tx_valid, bus.o_mem_we, bus.o_retrans_req,
                           bus.o_frame_done, bus.o_frame_drop, bus.o_busy}, 0);
    chk({name, "_data"}, {bus.o_tx_data, bus.o_mem_addr, bus.o_mem_wdata}, 0);
  endtask
  task automatic snap();
    d_done = n_done; d_drop = n_drop; d_xfer = n_xfer; d_rtx = n_rtx;
  endtask
  initial begin
    bus.i_arq_en = 1'b0;
    bus.i_otn_tx_ack = 1'b1;
    repeat (2) @(posedge clk);
    #2 chk_quiet("reset");
    rst = 1'b0;
    // ARQ off: one frame, done one cycle after the last byte.
    snap();
    load_frame(0, 8'h10, 0);
    wait_left(0, 200);
    wait_idle(50);
    chk("s1_done", n_done - d_done, 1);
    chk("s1_done_lat", done_cyc - last_xfer, 1);
    chk("s1_bytes", n_xfer - d_xfer, 16);
    chk("s1_no_retx", n_rtx - d_rtx, 0);
    chk("s1_wr_left", exp_wr.size(), 0);
    chk("s1_ram_last", ram[15], 8'h1F);
    // ARQ on, good ACK 50 cycles after the frame.
    bus.i_arq_en = 1'b1;
    snap();
    load_frame(0, 8'h40, 0);
    wait_left(0, 200);
    repeat (50) @(posedge clk);
    drive_ack(1'b0, 1'b1, 1'b0);
    wait_idle(100);
    chk("s2_done", n_done - d_done, 1);
    chk("s2_drop", n_drop - d_drop, 0);
    chk("s2_no_retx", n_rtx - d_rtx, 0);
    // NAK then good ACK: exactly one replay.
    snap();
    load_frame(0, 8'h80, 1);
    wait_left(FB, 200);
    drive_ack(1'b0, 1'b0, 1'b0);
    wait_left(0, 300);
    drive_ack(1'b0, 1'b1, 1'b0);
    wait_idle(100);
    chk("s3_done", n_done - d_done, 1);
    chk("s3_replay", n_rtx - d_rtx, 16);
    chk("s3_drop", n_drop - d_drop, 0);
    // Silent far end: three timed-out replays, then one drop.
    snap();
    waits.delete();
    load_frame(0, 8'hC0, 3);
    wait_left(0, 2000);
    wait_idle(500);
    chk("s4_drop", n_drop - d_drop, 1);
    chk("s4_done", n_done - d_done, 0);
    chk("s4_replay", n_rtx - d_rtx, 48);
    chk("s4_nwaits", waits.size(), 4);
    foreach (waits[i]) chk("s4_wait_len", waits[i], 100);
    // Random serializer backpressure on SEND and RETX_SEND, then with ARQ off.
    bp = 1'b1;
    snap();
    load_frame(0, 8'h33, 1);
    wait_left(FB, 500);
    drive_ack(1'b0, 1'b0, 1'b0);
    wait_left(0, 500);
    drive_ack(1'b0, 1'b1, 1'b0);
    wait_idle(100);
    chk("s5_done", n_done - d_done, 1);
    chk("s5_replay", n_rtx - d_rtx, 16);
    bus.i_arq_en = 1'b0;
    snap();
    load_frame(0, 8'h60, 0);
    wait_left(0, 500);
    wait_idle(50);
    chk("s5b_done", n_done - d_done, 1);
    bp = 1'b0;
    // Junk before FAS is discarded; reset during a replay abandons the frame silently.
    bus.i_arq_en = 1'b1;
    snap();
    load_frame(3, 8'hA0, 1);
    wait_left(FB, 200);
    chk("s6_junk_gone", fifo_q.size(), 0);
    chk("s6_wr_left", exp_wr.size(), 0);
    drive_ack(1'b0, 1'b0, 1'b0);
    begin
      int k = 0;
      while (n_rtx - d_rtx < 5 && k < 300) begin @(posedge clk); #2; k++; end
    end
    chk("s6_in_retx", bus.o_retrans_req, 1);
    rst = 1'b1;
    @(posedge clk);
    #2 chk_quiet("s6_rst");
    exp_tx.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    snap();
    repeat (150) @(posedge clk);
    #2;
    chk("s6_no_done", n_done - d_done, 0);
    chk("s6_no_drop", n_drop - d_drop, 0);
    chk("s6_idle", bus.o_busy, 0);
    // Recovery after reset.
    bus.i_arq_en = 1'b0;
    snap();
    load_frame(0, 8'h55, 0);
    wait_left(0, 200);
    wait_idle(50);
    chk("s7_done", n_done - d_done, 1);
    chk("s7_bytes", n_xfer - d_xfer, 16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arq_tx_ctrl.md
Name: arq_tx_ctrl

Overview:
Sequencing controller for the sender-side OTN transmit path with ARQ. It pops mapped frame bytes from the RX FIFO and streams them to the serializer, copying each byte into a retransmit buffer. With ARQ enabled it decodes the 3-bit serial ACK from the far end, replays the buffered frame on a bad, missing or malformed ACK, and stops retrying after a bounded retry count. It sits between the RX FIFO / retransmit RAM and the line serializer.

Parameters:
FRAME_BYTES, 4164, bytes per OTN frame; legal range 2..8191.
ACK_TIMEOUT, 16384, cycles in ACK wait before the ACK is declared missing; legal range 1..65535.
MAX_RETRY, 3, retransmissions allowed per frame; legal range 1..15.

Ports:
i_clk  in  1  single clock
i_rst  in  1  synchronous reset, active-high
i_arq_en  in  1  ARQ enable (board switch); sampled only at end of SEND
i_fifo_valid  in  1  FIFO byte available
i_fifo_data  in  8  FIFO byte
i_fifo_fas  in  1  byte is the first byte of a frame
o_fifo_ready  out  1  pop FIFO
o_tx_valid  out  1  byte to serializer valid
o_tx_data  out  8  byte to serializer
i_tx_ready  in  1  serializer accepts byte
o_mem_we  out  1  retransmit RAM write enable
o_mem_addr  out  13  retransmit RAM address
o_mem_wdata  out  8  retransmit RAM write data
i_mem_rdata  in  8  RAM read data; registered, 1-cycle latency
i_otn_tx_ack  in  1  asynchronous serial ACK line, idles high
o_retrans_req  out  1  high while a retransmission is in progress
o_frame_done  out  1  1-cycle pulse: frame completed (good ACK, or ARQ disabled)
o_frame_drop  out  1  1-cycle pulse: retries exhausted, frame abandoned
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; all counters 0; every output 0; sync flops preset to 1. A reset mid-frame abandons the frame and issues no done/drop pulse.
- ACK line passes through a 3-flop synchronizer, called ack_s below. One ACK bit lasts one i_clk cycle. Frame format is: start bit 0, ACK bit (1 = good, 0 = bad), stop bit 0. Low samples outside ACK_WAIT are ignored.
- IDLE:
  - o_fifo_ready=1.
  - A non-FAS byte is popped and discarded (resync).
  - A FAS byte (handshake with i_fifo_fas=1) is the first byte of a frame. It is treated as the first SEND transfer and moves to SEND with byte_cnt=1.
- SEND:
  - o_tx_valid=i_fifo_valid, o_tx_data=i_fifo_data, o_fifo_ready=i_tx_ready.
  - On each transfer (valid & ready): o_mem_we=1, o_mem_addr=byte_cnt, o_mem_wdata=data, then byte_cnt++. The IDLE FAS transfer writes address 0.
  - FAS on any later byte is ignored and treated as data.
  - After transfer number FRAME_BYTES: if i_arq_en=1, go to ACK_WAIT with retry=0 and timer=0. Otherwise pulse o_frame_done and go to IDLE.
- ACK_WAIT:
  - timer increments each cycle.
  - ack_s=0 moves to ACK_BIT. This wins over timeout in the same cycle.
  - timer==ACK_TIMEOUT-1 with no start bit counts as a bad ACK.
- ACK_BIT: latch ack_s into ack_val; go to ACK_STOP.
- ACK_STOP:
  - ack_s=0 and ack_val=1: pulse o_frame_done, go to IDLE.
  - Any other combination (bad ACK, or framing error) counts as a bad ACK.
- Bad ACK: if retry==MAX_RETRY, pulse o_frame_drop and go to IDLE. Otherwise retry++ and go to RETX_PRIME.
- RETX_PRIME: 1 cycle. rd_ptr=0, o_mem_addr=0, o_retrans_req=1.
- RETX_SEND:
  - o_tx_valid=1, o_tx_data=i_mem_rdata, o_retrans_req=1, o_fifo_ready=0.
  - o_mem_addr is combinational: rd_ptr+1 on a transfer, else rd_ptr. This holds rdata stable under backpressure and gives full throughput.
  - After transfer number FRAME_BYTES, go to ACK_WAIT with timer=0.
- The FIFO is never popped outside IDLE and SEND.
- byte_cnt and rd_ptr are 13 bits; timer is 16 bits; retry is 4 bits. None of them wraps within a legal frame.

Test Plan:
1. ARQ off, FRAME_BYTES=4164, tx_ready=1 -> 4164 bytes out in order, RAM addresses 0..4163 written, o_frame_done pulses 1 cycle after the last byte, 0 retransmissions.
2. ARQ on, ACK sequence 0,1,0 arriving 50 cycles after the frame -> o_frame_done pulses, o_retrans_req never asserts.
3. ARQ on, ACK 0,0,0 then 0,1,0 -> exactly one replay of RAM bytes 0..4163 matching the original frame with o_retrans_req high throughout, then o_frame_done.
4. ARQ on, no ACK, ACK_TIMEOUT=100, MAX_RETRY=3 -> 3 replays, each preceded by a 100-cycle wait, then a single o_frame_drop pulse, return to IDLE.
5. Random tx_ready backpressure during SEND and RETX_SEND -> no byte lost or duplicated; o_tx_data stays stable while valid and not ready.
6. Non-FAS bytes before the first FAS are discarded; i_rst asserted mid-RETX_SEND -> next cycle all outputs 0, state IDLE, no done/drop pulse.
